// File: rtl/homomorphic_rescale_pkg.sv
// homomorphic_rescale_pkg: shared BFV rescale widths, moduli and lane-slice helper
package homomorphic_rescale_pkg;
   localparam int PLAINTEXT_MODULUS = 64;
   localparam int PLAINTEXT_WIDTH = 6;
   localparam int CIPHERTEXT_MODULUS = 1024;
   localparam int Q_WIDTH = 10;
   localparam int CIPHERTEXT_WIDTH = 21;
   localparam int PARALLEL = 2;
   localparam int BEATS = 15;
   localparam int PRODUCT_WIDTH = CIPHERTEXT_WIDTH + PLAINTEXT_WIDTH + 1;
   localparam int BEAT_WIDTH = BEATS > 1 ? $clog2(BEATS) : 1;

   function automatic logic [CIPHERTEXT_WIDTH-1:0] in_lane(input logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] d, input int k);
      return d[k*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH];
   endfunction
endpackage

// File: rtl/homomorphic_rescale_if.sv
// homomorphic_rescale_if: input partial stream and output coefficient stream of the rescale stage
interface homomorphic_rescale_if;
   import homomorphic_rescale_pkg::*;
   logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] in_data;
   logic in_valid;
   logic in_ready;
   logic [PARALLEL*Q_WIDTH-1:0] out_data;
   logic out_valid;
   logic out_ready;
   logic out_last;
   modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, out_last);
   modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/homomorphic_rescale_lane.sv
// homomorphic_rescale_lane: one lane of round(x*t/q) mod q; RESCALE_OVF_EN adds the wrap-loss flag
module homomorphic_rescale_lane
   import homomorphic_rescale_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic adv,
   input  logic [CIPHERTEXT_WIDTH-1:0] x,
`ifdef RESCALE_OVF_EN
   output logic ovf,
`endif
   output logic [Q_WIDTH-1:0] y
);
`ifdef RESCALE_OVF_EN
   localparam int HW = PRODUCT_WIDTH - Q_WIDTH;
`else
   localparam int HW = Q_WIDTH;
`endif
   logic [PRODUCT_WIDTH-1:0] p;
   logic [HW-1:0] p_hi;
   assign p = (PRODUCT_WIDTH'(x) << PLAINTEXT_WIDTH) + (PRODUCT_WIDTH'(1) << (Q_WIDTH - 1));
   // S1: scale by t with half-q bias, keeping only bits at and above the rounding point
   always_ff @(posedge clk)
      if (rst) p_hi <= '0;
      else if (adv) p_hi <= HW'(p >> Q_WIDTH);
   // S2: the low Q_WIDTH bits of the quotient are the mod-q result
   always_ff @(posedge clk)
      if (rst) y <= '0;
      else if (adv) y <= p_hi[Q_WIDTH-1:0];
`ifdef RESCALE_OVF_EN
   assign ovf = |p_hi[HW-1:Q_WIDTH];
`endif
endmodule

// File: rtl/homomorphic_rescale.sv
// homomorphic_rescale: 2-stage BFV rescale stream with component beat counter; RESCALE_OVF_EN adds ovf_sticky
module homomorphic_rescale
   import homomorphic_rescale_pkg::*;
(
   input  logic clk,
   input  logic rst,
`ifdef RESCALE_OVF_EN
   output logic ovf_sticky,
`endif
   homomorphic_rescale_if.slave io
);
   localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);
   logic adv;
   logic s1_valid;
   logic out_valid;
   logic [BEAT_WIDTH-1:0] beat_cnt;
   logic [PARALLEL-1:0][Q_WIDTH-1:0] y;
`ifdef RESCALE_OVF_EN
   logic [PARALLEL-1:0] lane_ovf;
`endif
   assign adv = !out_valid | io.out_ready;
   assign io.in_ready = adv;
   assign io.out_valid = out_valid;
   assign io.out_last = out_valid & (beat_cnt == LAST_BEAT);
   assign io.out_data = y;
   for (genvar i = 0; i < PARALLEL; i++) begin : g_lane
      homomorphic_rescale_lane u_lane (
         .clk(clk),
         .rst(rst),
         .adv(adv),
         .x(in_lane(io.in_data, i)),
`ifdef RESCALE_OVF_EN
         .ovf(lane_ovf[i]),
`endif
         .y(y[i])
      );
   end
   // valid bits move with the lane data whenever the pipe advances
   always_ff @(posedge clk)
      if (rst) {s1_valid, out_valid} <= '0;
      else if (adv) {s1_valid, out_valid} <= {io.in_valid, s1_valid};
   // count accepted output beats to mark the end of each component
   always_ff @(posedge clk)
      if (rst) beat_cnt <= '0;
      else if (out_valid && io.out_ready) beat_cnt <= beat_cnt == LAST_BEAT ? '0 : beat_cnt + 1'b1;
`ifdef RESCALE_OVF_EN
   // latch any lane whose wrapped-away bits were nonzero on a valid S2 load
   always_ff @(posedge clk)
      if (rst) ovf_sticky <= 1'b0;
      else if (adv && s1_valid && |lane_ovf) ovf_sticky <= 1'b1;
`endif
endmodule

// File: tb/tb_homomorphic_rescale.sv
// tb_homomorphic_rescale: scoreboard bench for homomorphic_rescale (checks ovf_sticky when RESCALE_OVF_EN is defined)
module tb_homomorphic_rescale;
   import homomorphic_rescale_pkg::*;
   localparam int DW = PARALLEL * CIPHERTEXT_WIDTH;
   localparam int OW = PARALLEL * Q_WIDTH;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   int mcnt = 0;
   logic [OW-1:0] sb[$];
   logic [OW-1:0] want;
   homomorphic_rescale_if io ();
`ifdef RESCALE_OVF_EN
   logic ovf_sticky;
`endif
   homomorphic_rescale dut (
      .clk(clk),
      .rst(rst),
`ifdef RESCALE_OVF_EN
      .ovf_sticky(ovf_sticky),
`endif
      .io(io)
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] model(input logic [DW-1:0] d);
      logic [OW-1:0] r;
      longint x;
      r = '0;
      for (int k = 0; k < PARALLEL; k++) begin
         x = longint'(d[k*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH]);
         r[k*Q_WIDTH +: Q_WIDTH] = Q_WIDTH'(((x * PLAINTEXT_MODULUS + CIPHERTEXT_MODULUS / 2) / CIPHERTEXT_MODULUS) % CIPHERTEXT_MODULUS);
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] pack(input int unsigned a, input int unsigned b);
      return {CIPHERTEXT_WIDTH'(b), CIPHERTEXT_WIDTH'(a)};
   endfunction

   // scoreboard: expected coefficients queued on input transfers, checked on output transfers
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         mcnt = 0;
      end else begin
         if (io.out_valid && io.out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL sb_underflow: got %h with nothing expected", io.out_data);
            end else begin
               want = sb.pop_front();
               if (io.out_data !== want) begin
                  miscompares++;
                  $display("FAIL sb_data: got %h expected %h", io.out_data, want);
               end
            end
            vectors++;
            if (io.out_last !== (mcnt == BEATS - 1)) begin
               miscompares++;
               $display("FAIL sb_last: got %b expected %b at beat %0d", io.out_last, mcnt == BEATS - 1, mcnt);
            end
            mcnt = mcnt == BEATS - 1 ? 0 : mcnt + 1;
         end
         if (io.in_valid && io.in_ready) sb.push_back(model(io.in_data));
      end
   end

   task automatic set_in(input logic v, input logic [DW-1:0] d, input logic r);
      io.in_valid = v;
      io.in_data = d;
      io.out_ready = r;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b0, '0, 1'b1);
      next();
      next();
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && sb.size() > 0; c++) begin
         set_in(1'b0, '0, 1'b1);
         next();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b1, pack(100, 200), 1'b1);
      next();
      next();
      @(negedge clk);
      vectors++;
      if (io.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", io.out_valid); end
      vectors++;
      if (io.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b expected 0", io.out_last); end
      vectors++;
      if (io.out_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", io.out_data); end
      vectors++;
      if (io.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", io.in_ready); end
`ifdef RESCALE_OVF_EN
      vectors++;
      if (ovf_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf_sticky); end
`endif
      rst = 1'b0;
      set_in(1'b0, '0, 1'b1);
      next();
   endtask

   task automatic test_rounding();
      logic [DW-1:0] beats [4];
      logic [OW-1:0] exp_out [4];
      beats = '{pack(1, 2), pack(8, 24), pack(7, 24), pack(1048575, 1048575)};
      exp_out = '{{10'd0, 10'd0}, {10'd2, 10'd1}, {10'd2, 10'd0}, {10'd0, 10'd0}};
      do_reset();
      for (int k = 0; k < 8; k++) begin
         set_in(k < 4, k < 4 ? beats[k] : '0, 1'b1);
         @(negedge clk);
         vectors++;
         if (io.out_valid !== (k >= 2 && k < 6)) begin
            miscompares++;
            $display("FAIL latency_valid: cycle %0d got %b expected %b", k, io.out_valid, k >= 2 && k < 6);
         end
         if (k >= 2 && k < 6) begin
            vectors++;
            if (io.out_data !== exp_out[k-2]) begin
               miscompares++;
               $display("FAIL round_data: cycle %0d got %h expected %h", k, io.out_data, exp_out[k-2]);
            end
         end
`ifdef RESCALE_OVF_EN
         if (k == 4 || k == 5) begin
            vectors++;
            if (ovf_sticky !== (k == 5)) begin
               miscompares++;
               $display("FAIL ovf_sticky: cycle %0d got %b expected %b", k, ovf_sticky, k == 5);
            end
         end
`endif
         next();
      end
      drain();
      vectors++;
      if (sb.size() != 0) begin miscompares++; $display("FAIL round_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      int n;
      n = 0;
      do_reset();
      for (int k = 0; k < BEATS + 3; k++) begin
         set_in(k < BEATS + 1, pack(k * 37, k * 1000 + 5), 1'b1);
         @(negedge clk);
         if (io.out_valid && io.out_ready) begin
            n++;
            vectors++;
            if (io.out_last !== (n == BEATS)) begin
               miscompares++;
               $display("FAIL b2b_last: output %0d got %b expected %b", n, io.out_last, n == BEATS);
            end
         end
         next();
      end
      vectors++;
      if (n != BEATS + 1) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", n, BEATS + 1); end
      drain();
      vectors++;
      if (sb.size() != 0) begin miscompares++; $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_backpressure();
      int i;
      logic r;
      logic [OW-1:0] snap;
      i = 0;
      snap = '0;
      do_reset();
      for (int c = 0; c < 40; c++) begin
         r = !(c >= 6 && c < 11);
         set_in(i < 12, pack(i * 91 + 3, i * 4093), r);
         @(negedge clk);
         if (!r) begin
            vectors++;
            if (io.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready: cycle %0d got %b expected 0", c, io.in_ready); end
            if (c == 6) snap = io.out_data;
            else begin
               vectors++;
               if (io.out_data !== snap) begin miscompares++; $display("FAIL bp_stable: cycle %0d got %h expected %h", c, io.out_data, snap); end
            end
         end
         if (io.in_valid && io.in_ready) i++;
         next();
      end
      drain();
      vectors++;
      if (i != 12 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL bp_drain: sent %0d pending %0d expected 12 and 0", i, sb.size());
      end
   endtask

   task automatic test_random();
      int sent;
      int c;
      sent = 0;
      c = 0;
      do_reset();
      while (sent < 1000 && c < 20000) begin
         set_in(1'($urandom_range(0, 1)), pack($urandom_range(0, 2097151), $urandom_range(0, 2097151)), 1'($urandom_range(0, 1)));
         @(negedge clk);
         if (io.in_valid && io.in_ready) sent++;
         next();
         c++;
      end
      drain();
      vectors++;
      if (sent != 1000 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL random_drain: sent %0d pending %0d expected 1000 and 0", sent, sb.size());
      end
   endtask

   task automatic test_reset_midstream();
      int n;
      n = 0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, pack(k + 11, k + 22), 1'b1);
         next();
      end
      drain();
      set_in(1'b1, pack(5, 6), 1'b0);
      next();
      set_in(1'b1, pack(7, 8), 1'b0);
      next();
      rst = 1'b1;
      set_in(1'b0, '0, 1'b0);
      next();
      rst = 1'b0;
      set_in(1'b0, '0, 1'b1);
      @(negedge clk);
      vectors++;
      if (io.out_valid !== 1'b0 || io.out_last !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: valid %b last %b expected 0 0", io.out_valid, io.out_last);
      end
      next();
      for (int k = 0; k < BEATS + 2; k++) begin
         set_in(k < BEATS, pack(k * 513, k * 77), 1'b1);
         @(negedge clk);
         if (io.out_valid && io.out_ready) begin
            n++;
            vectors++;
            if (io.out_last !== (n == BEATS)) begin
               miscompares++;
               $display("FAIL mid_last: output %0d got %b expected %b", n, io.out_last, n == BEATS);
            end
         end
         next();
      end
      drain();
      vectors++;
      if (n != BEATS || sb.size() != 0) begin
         miscompares++;
         $display("FAIL mid_count: outputs %0d pending %0d expected %0d and 0", n, sb.size(), BEATS);
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      set_in(1'b0, '0, 1'b1);
      test_reset();
      test_rounding();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
